// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
//   state_e  : arbiter FSM state (idle, fetch in flight, data access in flight)
//   grant_e  : grant decision produced by mem_arb_pick
//   STREAK_W : width of the consecutive-data-grant counter
package mem_arb_pkg;

  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the arbiter's requester and memory-side signals.
//   fetch requester : if_req, if_addr, if_kill -> if_done, if_rdata, stall_f
//   data requester  : d_req, d_we, d_addr, d_wdata -> d_done, d_rdata, stall_m
//   memory          : mem_req, mem_we, mem_addr, mem_wdata <- mem_ack, mem_rdata
// Modport master is the arbiter's view; slave is the core + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_kill;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          stall_f;
  logic          stall_m;

  modport master (
    input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output stall_f, stall_m
  );

  modport slave (
    output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_f, stall_m
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory-port arbiter (combinational).
//   if_elig_i : fetch request eligible this cycle
//   d_elig_i  : data request eligible this cycle
//   streak_i  : consecutive data grants taken while a fetch was waiting
//   grant_o   : GNT_D normally wins; GNT_IF wins once the streak hits MAX_STREAK
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                if_elig_i,
  input  logic                d_elig_i,
  input  logic [STREAK_W-1:0] streak_i,
  output grant_e              grant_o
);

  localparam logic [STREAK_W-1:0] StreakCap = STREAK_W'(MAX_STREAK);

  always_comb begin
    grant_o = GNT_NONE;
    if (if_elig_i && (!d_elig_i || streak_i == StreakCap)) begin
      grant_o = GNT_IF;
    end else if (d_elig_i) begin
      grant_o = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and
// load/store. One transaction at a time; data has priority, but after MAX_STREAK
// data grants taken while a fetch waited, the fetch is served next.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester, memory and stall signals (mem_port_arbiter_if.master)
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [STREAK_W-1:0] StreakCap = STREAK_W'(MAX_STREAK);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                kill_pend_q, kill_pend_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic [DW-1:0]       if_rdata_q, if_rdata_d;
  logic                d_done_q, d_done_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;

  logic   if_elig, d_elig;
  grant_e grant;

  // A requester keeps req high through its done cycle; mask it so the finished
  // request is not granted a second time.
  assign if_elig = bus.if_req & ~bus.if_kill & ~if_done_q;
  assign d_elig  = bus.d_req & ~d_done_q;

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK)
  ) u_pick (
    .if_elig_i (if_elig),
    .d_elig_i  (d_elig),
    .streak_i  (streak_q),
    .grant_o   (grant)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    kill_pend_d = kill_pend_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_done_d    = 1'b0;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        unique case (grant)
          GNT_IF: begin
            state_d     = ST_FETCH;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
          GNT_D: begin
            state_d     = ST_DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            // Only count data grants that actually made a fetch wait.
            if (bus.if_req) begin
              streak_d = (streak_q == StreakCap) ? streak_q : streak_q + 1'b1;
            end else begin
              streak_d = '0;
            end
          end
          default: ;
        endcase
      end
      ST_FETCH: begin
        if (bus.mem_ack) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          kill_pend_d = 1'b0;
          // A redirect seen at any point of the access discards its result.
          if (!(kill_pend_q || bus.if_kill)) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (bus.if_kill) begin
          kill_pend_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      kill_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_pend_q <= kill_pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.stall_f = bus.if_req & ~if_done_q;
  assign bus.stall_m = bus.d_req & ~d_done_q;

endmodule
